// File: rtl/gates_pkg.sv
// Shared definitions for the two-input logic-gate lab: output bit positions,
// the reference gate function and the checker state encoding.
package gates_pkg;

    localparam int Z_AND  = 0;
    localparam int Z_NAND = 1;
    localparam int Z_OR   = 2;
    localparam int Z_NOR  = 3;
    localparam int Z_XOR  = 4;
    localparam int Z_XNOR = 5;
    localparam int Z_W    = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    function automatic logic [Z_W-1:0] gates_expected(input logic a, input logic b);
        logic [Z_W-1:0] v;
        v[Z_AND]  = a & b;
        v[Z_NAND] = ~(a & b);
        v[Z_OR]   = a | b;
        v[Z_NOR]  = ~(a | b);
        v[Z_XOR]  = a ^ b;
        v[Z_XNOR] = ~(a ^ b);
        return v;
    endfunction

endpackage

// File: rtl/ab_delay_line.sv
// Shift register that delays the {b,a} stimulus pair by LATENCY clocks so it
// lines up with a registered DUT response; LATENCY=0 is a straight wire.
module ab_delay_line #(
    parameter int LATENCY = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] ab_in,
    output logic [1:0] ab_out
);

    // One dummy stage is kept for LATENCY=0 so the array is never zero-sized.
    localparam int DEPTH = (LATENCY == 0) ? 1 : LATENCY;

    logic [1:0] stage [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= ab_in;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign ab_out = (LATENCY == 0) ? ab_in : stage[DEPTH-1];

endmodule

// File: rtl/gates_response_checker.sv
// Response monitor for the gate lab DUTs: compares z against the expected gate
// vector of the latency-aligned stimulus and accumulates error/coverage stats.
module gates_response_checker
    import gates_pkg::*;
#(
    parameter int LATENCY   = 0,
    parameter int N_VECTORS = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       a,
    input  logic       b,
    input  logic [5:0] z,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] err_count,
    output logic [1:0] first_err_ab,
    output logic [5:0] first_err_diff,
    output logic [3:0] coverage
);

    localparam logic [1:0] ARM_LAST    = LATENCY[1:0];
    localparam logic [7:0] SAMPLE_LAST = 8'(N_VECTORS - 1);

    state_t     state, state_next;
    logic [1:0] arm_cnt, arm_cnt_next;
    logic [7:0] sample_cnt, sample_cnt_next;
    logic [7:0] err_count_next;
    logic [1:0] first_err_ab_next;
    logic [5:0] first_err_diff_next;
    logic [3:0] coverage_next;
    logic       pass_next;

    logic [1:0] ab_delayed;
    logic [5:0] exp_vec;
    logic [5:0] diff;
    logic       mismatch;

    ab_delay_line #(.LATENCY(LATENCY)) u_delay (
        .clk    (clk),
        .rst_n  (rst_n),
        .ab_in  ({b, a}),
        .ab_out (ab_delayed)
    );

    // Four-state inequality so an X on z or on the stimulus counts as a failure.
    always_comb begin
        exp_vec  = gates_expected(ab_delayed[0], ab_delayed[1]);
        diff     = exp_vec ^ z;
        mismatch = (z !== exp_vec);
    end

    always_comb begin
        state_next          = state;
        arm_cnt_next        = arm_cnt;
        sample_cnt_next     = sample_cnt;
        err_count_next      = err_count;
        first_err_ab_next   = first_err_ab;
        first_err_diff_next = first_err_diff;
        coverage_next       = coverage;
        pass_next           = pass;

        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_next          = ST_ARM;
                    arm_cnt_next        = 2'd0;
                    sample_cnt_next     = 8'd0;
                    err_count_next      = 8'd0;
                    first_err_ab_next   = 2'd0;
                    first_err_diff_next = 6'd0;
                    coverage_next       = 4'd0;
                    pass_next           = 1'b0;
                end
            end
            ST_ARM: begin
                if (arm_cnt == ARM_LAST) begin
                    state_next = ST_RUN;
                end else begin
                    arm_cnt_next = arm_cnt + 2'd1;
                end
            end
            ST_RUN: begin
                // err_count is still zero exactly when no earlier sample failed.
                if (mismatch) begin
                    if (err_count == 8'd0) begin
                        first_err_ab_next   = ab_delayed;
                        first_err_diff_next = diff;
                    end
                    if (err_count != 8'hFF) begin
                        err_count_next = err_count + 8'd1;
                    end
                end
                coverage_next[ab_delayed] = 1'b1;
                sample_cnt_next           = sample_cnt + 8'd1;
                if (sample_cnt == SAMPLE_LAST) begin
                    state_next = ST_DONE;
                    pass_next  = (err_count_next == 8'd0) && (coverage_next == 4'hF);
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            arm_cnt        <= 2'd0;
            sample_cnt     <= 8'd0;
            err_count      <= 8'd0;
            first_err_ab   <= 2'd0;
            first_err_diff <= 6'd0;
            coverage       <= 4'd0;
            pass           <= 1'b0;
        end else begin
            state          <= state_next;
            arm_cnt        <= arm_cnt_next;
            sample_cnt     <= sample_cnt_next;
            err_count      <= err_count_next;
            first_err_ab   <= first_err_ab_next;
            first_err_diff <= first_err_diff_next;
            coverage       <= coverage_next;
            pass           <= pass_next;
        end
    end

    assign busy = (state == ST_ARM) || (state == ST_RUN);
    assign done = (state == ST_DONE);

endmodule

// File: tb/tb_gates_response_checker.sv
// Self-checking bench for gates_response_checker: three checker instances with
// different latency/length, each fed by emulated good or faulty DUT responses.
module tb_gates_response_checker;

    localparam int PAT_COUNT = 0;
    localparam int PAT_RAND  = 1;
    localparam int PAT_HELD  = 2;
    localparam int Z_GOOD    = 0;
    localparam int Z_STUCK4  = 1;
    localparam int Z_REG2    = 2;
    localparam int Z_ZERO    = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       a, b;
    logic       start_l0, start_l2, start_sat;
    logic [5:0] z_l0, z_l2, z_sat;

    logic       busy_l0, done_l0, pass_l0, busy_l2, done_l2, pass_l2, busy_sat, done_sat, pass_sat;
    logic [7:0] err_l0, err_l2, err_sat;
    logic [1:0] fab_l0, fab_l2, fab_sat;
    logic [5:0] fdiff_l0, fdiff_l2, fdiff_sat;
    logic [3:0] cov_l0, cov_l2, cov_sat;

    int checks = 0;
    int errors = 0;

    logic [1:0] ab_h [0:299];
    logic [5:0] z_h  [0:299];
    int         exp_err;
    logic [1:0] exp_fab;
    logic [5:0] exp_fdiff;
    logic [3:0] exp_cov;
    logic       exp_pass;

    always #5 clk = ~clk;

    gates_response_checker #(.LATENCY(0), .N_VECTORS(16)) u_l0 (
        .clk(clk), .rst_n(rst_n), .start(start_l0), .a(a), .b(b), .z(z_l0),
        .busy(busy_l0), .done(done_l0), .pass(pass_l0), .err_count(err_l0),
        .first_err_ab(fab_l0), .first_err_diff(fdiff_l0), .coverage(cov_l0)
    );

    gates_response_checker #(.LATENCY(2), .N_VECTORS(16)) u_l2 (
        .clk(clk), .rst_n(rst_n), .start(start_l2), .a(a), .b(b), .z(z_l2),
        .busy(busy_l2), .done(done_l2), .pass(pass_l2), .err_count(err_l2),
        .first_err_ab(fab_l2), .first_err_diff(fdiff_l2), .coverage(cov_l2)
    );

    gates_response_checker #(.LATENCY(0), .N_VECTORS(255)) u_sat (
        .clk(clk), .rst_n(rst_n), .start(start_sat), .a(a), .b(b), .z(z_sat),
        .busy(busy_sat), .done(done_sat), .pass(pass_sat), .err_count(err_sat),
        .first_err_ab(fab_sat), .first_err_diff(fdiff_sat), .coverage(cov_sat)
    );

    // Gate truth derived from how many inputs are high.
    function automatic logic [5:0] ref_gates(input logic [1:0] ab);
        int  ones;
        logic g_and, g_or, g_xor;
        ones  = int'(ab[0]) + int'(ab[1]);
        g_and = (ones == 2);
        g_or  = (ones >= 1);
        g_xor = (ones == 1);
        return {~g_xor, g_xor, ~g_or, g_or, ~g_and, g_and};
    endfunction

    function automatic int inst_lat(input int inst);
        return (inst == 1) ? 2 : 0;
    endfunction

    function automatic int inst_n(input int inst);
        return (inst == 2) ? 255 : 16;
    endfunction

    task automatic read_out(input int inst, output logic bo, output logic dn, output logic ps,
                            output logic [7:0] er, output logic [1:0] fa, output logic [5:0] fd,
                            output logic [3:0] cv);
        case (inst)
            0:       begin bo = busy_l0;  dn = done_l0;  ps = pass_l0;  er = err_l0;  fa = fab_l0;  fd = fdiff_l0;  cv = cov_l0;  end
            1:       begin bo = busy_l2;  dn = done_l2;  ps = pass_l2;  er = err_l2;  fa = fab_l2;  fd = fdiff_l2;  cv = cov_l2;  end
            default: begin bo = busy_sat; dn = done_sat; ps = pass_sat; er = err_sat; fa = fab_sat; fd = fdiff_sat; cv = cov_sat; end
        endcase
    endtask

    // Start a run on one instance, drive stimulus and emulated DUT responses for
    // the whole run, then derive the expected result from the recorded history.
    // Cycle k is the clock period ending at rising edge k; start is high in cycle 0.
    task automatic do_run(input int inst, input int pat, input int zmode, input int x_cycle,
                          input int extra_start);
        int         lat, n, last;
        logic [1:0] ab;
        logic [5:0] zv, e;
        logic       bo, dn, ps, st;
        logic [7:0] er;
        logic [1:0] fa;
        logic [5:0] fd;
        logic [3:0] cv;
        lat  = inst_lat(inst);
        n    = inst_n(inst);
        last = lat + n + 1;
        for (int k = 0; k <= last; k++) begin
            @(negedge clk);
            if (k == last) begin
                read_out(inst, bo, dn, ps, er, fa, fd, cv);
                checks++;
                if ({bo, dn} !== 2'b10) begin
                    errors++;
                    $display("[TB] FAIL run_busy_before_done inst=%0d actual busy/done=%b%b required 10", inst, bo, dn);
                end
            end
            case (pat)
                PAT_COUNT: ab = 2'(k + 3);
                PAT_RAND:  ab = 2'($urandom_range(0, 3));
                default:   ab = 2'b11;
            endcase
            case (zmode)
                Z_GOOD:   zv = ref_gates(ab);
                Z_STUCK4: zv = ref_gates(ab) & 6'b101111;
                Z_REG2:   zv = (k >= 2) ? ref_gates(ab_h[k-2]) : 6'b0;
                default:  zv = 6'b0;
            endcase
            if (k == x_cycle) zv = 6'bxxxxxx;
            ab_h[k] = ab;
            z_h[k]  = zv;
            a       = ab[0];
            b       = ab[1];
            st      = (k == 0) || (k == extra_start);
            case (inst)
                0:       begin z_l0  = zv; start_l0  = st; end
                1:       begin z_l2  = zv; start_l2  = st; end
                default: begin z_sat = zv; start_sat = st; end
            endcase
        end
        @(negedge clk);
        exp_err   = 0;
        exp_fab   = 2'b00;
        exp_fdiff = 6'b0;
        exp_cov   = 4'b0;
        for (int t = lat + 2; t <= last; t++) begin
            e = ref_gates(ab_h[t-lat]);
            if (z_h[t] !== e) begin
                if (exp_err == 0) begin
                    exp_fab   = ab_h[t-lat];
                    exp_fdiff = e ^ z_h[t];
                end
                if (exp_err < 255) exp_err++;
            end
            exp_cov[ab_h[t-lat]] = 1'b1;
        end
        exp_pass = (exp_err == 0) && (exp_cov == 4'hF);
    endtask

    task automatic test_reset();
        logic bo, dn, ps;
        logic [7:0] er;
        logic [1:0] fa;
        logic [5:0] fd;
        logic [3:0] cv;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            read_out(i, bo, dn, ps, er, fa, fd, cv);
            checks++;
            if ({bo, dn, ps, er, fa, fd, cv} !== 23'd0) begin
                errors++;
                $display("[TB] FAIL reset_outputs inst=%0d actual=%h required=0", i, {bo, dn, ps, er, fa, fd, cv});
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_counter_good();
        do_run(0, PAT_COUNT, Z_GOOD, -1, -1);
        checks++; if (done_l0 !== 1'b1) begin errors++; $display("[TB] FAIL good_done actual=%b required=1", done_l0); end
        checks++; if (pass_l0 !== exp_pass) begin errors++; $display("[TB] FAIL good_pass actual=%b required=%b", pass_l0, exp_pass); end
        checks++; if (err_l0 !== 8'(exp_err)) begin errors++; $display("[TB] FAIL good_err actual=%0d required=%0d", err_l0, exp_err); end
        checks++; if (cov_l0 !== exp_cov) begin errors++; $display("[TB] FAIL good_cov actual=%b required=%b", cov_l0, exp_cov); end
    endtask

    task automatic test_stuck_xor();
        do_run(0, PAT_COUNT, Z_STUCK4, -1, -1);
        checks++; if (err_l0 !== 8'(exp_err)) begin errors++; $display("[TB] FAIL stuck_err actual=%0d required=%0d", err_l0, exp_err); end
        checks++; if (fab_l0 !== exp_fab) begin errors++; $display("[TB] FAIL stuck_first_ab actual=%b required=%b", fab_l0, exp_fab); end
        checks++; if (fdiff_l0 !== exp_fdiff) begin errors++; $display("[TB] FAIL stuck_first_diff actual=%b required=%b", fdiff_l0, exp_fdiff); end
        checks++; if (pass_l0 !== exp_pass) begin errors++; $display("[TB] FAIL stuck_pass actual=%b required=%b", pass_l0, exp_pass); end
    endtask

    task automatic test_random_restart_ignored();
        do_run(0, PAT_RAND, Z_GOOD, -1, 6);
        checks++; if (done_l0 !== 1'b1) begin errors++; $display("[TB] FAIL rand_done actual=%b required=1", done_l0); end
        checks++; if (err_l0 !== 8'(exp_err)) begin errors++; $display("[TB] FAIL rand_err actual=%0d required=%0d", err_l0, exp_err); end
        checks++; if (cov_l0 !== exp_cov) begin errors++; $display("[TB] FAIL rand_cov actual=%b required=%b", cov_l0, exp_cov); end
        checks++; if (pass_l0 !== exp_pass) begin errors++; $display("[TB] FAIL rand_pass actual=%b required=%b", pass_l0, exp_pass); end
    endtask

    task automatic test_latency();
        do_run(1, PAT_COUNT, Z_REG2, -1, -1);
        checks++; if (done_l2 !== 1'b1) begin errors++; $display("[TB] FAIL lat2_done actual=%b required=1", done_l2); end
        checks++; if (pass_l2 !== exp_pass) begin errors++; $display("[TB] FAIL lat2_pass actual=%b required=%b", pass_l2, exp_pass); end
        checks++; if (err_l2 !== 8'(exp_err)) begin errors++; $display("[TB] FAIL lat2_err actual=%0d required=%0d", err_l2, exp_err); end
        do_run(0, PAT_COUNT, Z_REG2, -1, -1);
        checks++; if (err_l0 !== 8'(exp_err)) begin errors++; $display("[TB] FAIL lat0_on_reg2_err actual=%0d required=%0d", err_l0, exp_err); end
        checks++; if (fdiff_l0 !== exp_fdiff) begin errors++; $display("[TB] FAIL lat0_on_reg2_diff actual=%b required=%b", fdiff_l0, exp_fdiff); end
        checks++; if (pass_l0 !== exp_pass) begin errors++; $display("[TB] FAIL lat0_on_reg2_pass actual=%b required=%b", pass_l0, exp_pass); end
    endtask

    task automatic test_held_stimulus();
        do_run(0, PAT_HELD, Z_GOOD, -1, -1);
        checks++; if (cov_l0 !== exp_cov) begin errors++; $display("[TB] FAIL held_cov actual=%b required=%b", cov_l0, exp_cov); end
        checks++; if (err_l0 !== 8'(exp_err)) begin errors++; $display("[TB] FAIL held_err actual=%0d required=%0d", err_l0, exp_err); end
        checks++; if (pass_l0 !== exp_pass) begin errors++; $display("[TB] FAIL held_pass actual=%b required=%b", pass_l0, exp_pass); end
    endtask

    task automatic test_x_response();
        do_run(0, PAT_RAND, Z_GOOD, 7, -1);
        checks++; if (err_l0 !== 8'(exp_err)) begin errors++; $display("[TB] FAIL xz_err actual=%0d required=%0d", err_l0, exp_err); end
        checks++; if (fab_l0 !== exp_fab) begin errors++; $display("[TB] FAIL xz_first_ab actual=%b required=%b", fab_l0, exp_fab); end
        checks++; if (pass_l0 !== exp_pass) begin errors++; $display("[TB] FAIL xz_pass actual=%b required=%b", pass_l0, exp_pass); end
    endtask

    task automatic test_saturate();
        do_run(2, PAT_RAND, Z_ZERO, -1, -1);
        checks++; if (done_sat !== 1'b1) begin errors++; $display("[TB] FAIL sat_done actual=%b required=1", done_sat); end
        checks++; if (err_sat !== 8'(exp_err)) begin errors++; $display("[TB] FAIL sat_err actual=%0d required=%0d", err_sat, exp_err); end
        checks++; if (pass_sat !== exp_pass) begin errors++; $display("[TB] FAIL sat_pass actual=%b required=%b", pass_sat, exp_pass); end
        do_run(2, PAT_COUNT, Z_GOOD, -1, -1);
        checks++; if (err_sat !== 8'(exp_err)) begin errors++; $display("[TB] FAIL sat_rerun_err actual=%0d required=%0d", err_sat, exp_err); end
        checks++; if (pass_sat !== exp_pass) begin errors++; $display("[TB] FAIL sat_rerun_pass actual=%b required=%b", pass_sat, exp_pass); end
    endtask

    task automatic test_reset_midrun();
        @(negedge clk);
        start_l0 = 1'b1;
        a = 1'b1; b = 1'b0;
        z_l0 = 6'b0;
        @(negedge clk);
        start_l0 = 1'b0;
        repeat (6) @(negedge clk);
        checks++; if (busy_l0 !== 1'b1) begin errors++; $display("[TB] FAIL midrun_busy actual=%b required=1", busy_l0); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy_l0, done_l0, pass_l0, err_l0, fab_l0, fdiff_l0, cov_l0} !== 23'd0) begin
            errors++;
            $display("[TB] FAIL midrun_reset actual=%h required=0", {busy_l0, done_l0, pass_l0, err_l0, fab_l0, fdiff_l0, cov_l0});
        end
        @(negedge clk);
        rst_n = 1'b1;
        do_run(0, PAT_COUNT, Z_GOOD, -1, -1);
        checks++; if (err_l0 !== 8'(exp_err)) begin errors++; $display("[TB] FAIL post_reset_err actual=%0d required=%0d", err_l0, exp_err); end
        checks++; if (pass_l0 !== exp_pass) begin errors++; $display("[TB] FAIL post_reset_pass actual=%b required=%b", pass_l0, exp_pass); end
        checks++; if (cov_l0 !== exp_cov) begin errors++; $display("[TB] FAIL post_reset_cov actual=%b required=%b", cov_l0, exp_cov); end
    endtask

    initial begin
        rst_n     = 1'b0;
        a         = 1'b0;
        b         = 1'b0;
        start_l0  = 1'b0;
        start_l2  = 1'b0;
        start_sat = 1'b0;
        z_l0      = 6'b0;
        z_l2      = 6'b0;
        z_sat     = 6'b0;
        test_reset();
        test_counter_good();
        test_stuck_xor();
        test_random_restart_ignored();
        test_latency();
        test_held_stimulus();
        test_x_response();
        test_saturate();
        test_reset_midrun();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
